forwarding_control: RTL

//  Hazard/forwarding controller for the 16-bit pipeline operand path. Tracks destination

---
 rtl/forwarding_control_if.sv | 44 ++++
 rtl/forwarding_control.sv | 105 ++++++++++
 2 files changed

// File: rtl/forwarding_control_if.sv
// ----------------------------------------------------------------------------
// forwarding_control_if
//   Bundle between the decode stage and the hazard/forwarding controller.
//   master : decode side. Drives the instruction fields and flush, and receives
//            the operand-mux selects, stall and the stall counter.
//   slave  : controller side (forwarding_control).
//
//   Handshake: id_valid is the decode stage's offer. The inverse of stall is
//   the controller's ready. An instruction is taken (issued into the tracking
//   pipe) on a rising clk edge where id_valid & ~stall & ~flush. While stall is
//   high the decode stage must hold its instruction fields unchanged.
// ----------------------------------------------------------------------------
interface forwarding_control_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_srcA;
  logic [REG_W-1:0] id_srcB;
  logic             id_useA;
  logic             id_useB;
  logic [REG_W-1:0] id_dst;
  logic             id_wr;
  logic             id_load;
  logic             flush;
  logic             One_A;
  logic             One_B;
  logic             Two_A;
  logic             Two_B;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_srcA, id_srcB, id_useA, id_useB,
    output id_dst, id_wr, id_load, flush,
    input  One_A, One_B, Two_A, Two_B, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_srcA, id_srcB, id_useA, id_useB,
    input  id_dst, id_wr, id_load, flush,
    output One_A, One_B, Two_A, Two_B, stall, stall_cnt
  );
endinterface

// File: rtl/forwarding_control.sv
// ----------------------------------------------------------------------------
// forwarding_control
//   Hazard/forwarding controller for the 16-bit pipeline operand path.
//   Tracks the two instructions issued ahead of decode (s1 = one cycle ago,
//   s2 = two cycles ago). From them it drives the operand-mux selects, stalls
//   decode for one cycle on a load-use hazard, and counts stall cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   fc         slave side of forwarding_control_if (decode fields in,
//              One_A/One_B/Two_A/Two_B, stall, stall_cnt out)
//   state_dbg  current controller state (0 = RUN, 1 = STALL)
// ----------------------------------------------------------------------------
module forwarding_control #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  forwarding_control_if.slave  fc,
  output logic [0:0]           state_dbg
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] dst;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  slot_t            s1_q;
  slot_t            s2_q;
  slot_t            id_slot;
  logic [CNT_W-1:0] cnt_q;

  logic hit1_a, hit1_b, hit2_a, hit2_b;
  logic one_a, one_b;
  logic lu, stall_int, issue, sel_en;

  assign id_slot = '{v: 1'b1, wr: fc.id_wr, load: fc.id_load, dst: fc.id_dst};

  // r0 reads as zero, so a source of r0 never matches a tracked producer,
  // even one that names r0 as its destination.
  assign hit1_a = fc.id_useA & s1_q.v & s1_q.wr & (s1_q.dst == fc.id_srcA) & (fc.id_srcA != '0);
  assign hit1_b = fc.id_useB & s1_q.v & s1_q.wr & (s1_q.dst == fc.id_srcB) & (fc.id_srcB != '0);
  assign hit2_a = fc.id_useA & s2_q.v & s2_q.wr & (s2_q.dst == fc.id_srcA) & (fc.id_srcA != '0);
  assign hit2_b = fc.id_useB & s2_q.v & s2_q.wr & (s2_q.dst == fc.id_srcB) & (fc.id_srcB != '0);

  // A load in s1 has no result on the One path yet; the consumer waits one
  // cycle and then picks the loaded value up from the Two path.
  assign lu = fc.id_valid & (hit1_a | hit1_b) & s1_q.load;

  // Only RUN can raise a stall. The cycle after a stall s1 is a bubble, so a
  // second back-to-back stall for the same consumer is impossible.
  assign stall_int = (state_q == ST_RUN) & lu & ~fc.flush;
  assign issue     = fc.id_valid & ~stall_int & ~fc.flush;
  assign sel_en    = fc.id_valid & ~stall_int;

  // Nearest producer wins: Two is only used when One is not selected.
  assign one_a = hit1_a & ~s1_q.load;
  assign one_b = hit1_b & ~s1_q.load;

  assign fc.One_A     = sel_en & one_a;
  assign fc.One_B     = sel_en & one_b;
  assign fc.Two_A     = sel_en & hit2_a & ~one_a;
  assign fc.Two_B     = sel_en & hit2_b & ~one_b;
  assign fc.stall     = stall_int;
  assign fc.stall_cnt = cnt_q;
  assign state_dbg    = state_q;

  // stall_int is already zero under flush, so flush always lands in RUN.
  always_comb begin
    state_d = ST_RUN;
    if (stall_int) state_d = ST_STALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      s1_q    <= BUBBLE;
      s2_q    <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fc.flush) begin
        s1_q <= BUBBLE;
        s2_q <= BUBBLE;
      end else begin
        s1_q <= issue ? id_slot : BUBBLE;
        s2_q <= s1_q;
      end
      // Saturate at all-ones rather than wrapping.
      if (stall_int && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
